// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback over a shared
// datapath, drives mux selects and write enables, and counts retired instructions.
module multicycle_ctrl #(
  parameter int CNT_W   = 32,
  parameter int ALUOP_W = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ack,
  output logic               mem_req,
  output logic               mem_we,
  output logic               mem_isd,
  output logic               ir_wr,
  output logic               pc_wr,
  output logic [2:0]         npc_sel,
  output logic               reg_wr,
  output logic [1:0]         rd_sel,
  output logic [1:0]         wd_sel,
  output logic [1:0]         alub_sel,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [CNT_W-1:0]   retired,
  output logic               illegal,
  output logic [3:0]         state_dbg
);

  // Memory handshake: mem_req rises and is held until the cycle mem_ack=1; read data is valid
  // in that ack cycle. mem_ack seen while mem_req=0 has no effect.

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_WB,
    S_MEM_ADDR, S_MEM, S_MEM_WB, S_BRANCH, S_JUMP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04;
  localparam logic [5:0] OP_ORI = 6'h0d, OP_LUI = 6'h0f, OP_LW = 6'h23, OP_SW = 6'h2b;
  localparam logic [5:0] FN_SLL = 6'h00, FN_JR = 6'h08, FN_ADDU = 6'h21, FN_SUBU = 6'h23;

  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(2);

  state_t state, state_nx;
  logic   count_inc, set_illegal;
  logic   is_r, is_addu, is_subu, is_jr, is_nop;
  logic   is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal;

  assign is_r    = (op == OP_RTYPE);
  assign is_addu = is_r && (funct == FN_ADDU);
  assign is_subu = is_r && (funct == FN_SUBU);
  assign is_jr   = is_r && (funct == FN_JR);
  assign is_nop  = is_r && (funct == FN_SLL);
  assign is_ori  = (op == OP_ORI);
  assign is_lui  = (op == OP_LUI);
  assign is_lw   = (op == OP_LW);
  assign is_sw   = (op == OP_SW);
  assign is_beq  = (op == OP_BEQ);
  assign is_j    = (op == OP_J);
  assign is_jal  = (op == OP_JAL);

  assign state_dbg = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_FETCH;
      retired <= '0;
      illegal <= 1'b0;
    end else begin
      state <= state_nx;
      if (count_inc)   retired <= retired + CNT_W'(1);
      if (set_illegal) illegal <= 1'b1;
    end
  end

  always_comb begin
    state_nx    = state;
    count_inc   = 1'b0;
    set_illegal = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_isd     = 1'b0;
    ir_wr       = 1'b0;
    pc_wr       = 1'b0;
    npc_sel     = 3'b000;
    reg_wr      = 1'b0;
    rd_sel      = 2'b00;
    wd_sel      = 2'b00;
    alub_sel    = 2'b00;
    alu_op      = ALU_ADD;
    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_wr    = 1'b1;
          pc_wr    = 1'b1;
          state_nx = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_addu || is_subu)            state_nx = S_EXEC_R;
        else if (is_ori || is_lui)         state_nx = S_EXEC_I;
        else if (is_lw || is_sw)           state_nx = S_MEM_ADDR;
        else if (is_beq)                   state_nx = S_BRANCH;
        else if (is_j || is_jal || is_jr)  state_nx = S_JUMP;
        else if (is_nop) begin
          state_nx  = S_FETCH;
          count_inc = 1'b1;
        end else begin
          state_nx    = S_FETCH;
          set_illegal = 1'b1;
        end
      end
      S_EXEC_R: begin
        alu_op   = is_subu ? ALU_SUB : ALU_ADD;
        state_nx = S_WB;
      end
      S_EXEC_I: begin
        if (is_ori) begin
          alub_sel = 2'b01;
          alu_op   = ALU_OR;
        end else begin
          alub_sel = 2'b11;
        end
        state_nx = S_WB;
      end
      S_WB: begin
        reg_wr    = 1'b1;
        rd_sel    = is_r ? 2'b01 : 2'b00;
        state_nx  = S_FETCH;
        count_inc = 1'b1;
      end
      S_MEM_ADDR: begin
        alub_sel = 2'b10;
        state_nx = S_MEM;
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_isd = 1'b1;
        mem_we  = is_sw;
        if (mem_ack) begin
          if (is_sw) begin
            state_nx  = S_FETCH;
            count_inc = 1'b1;
          end else begin
            state_nx = S_MEM_WB;
          end
        end
      end
      S_MEM_WB: begin
        reg_wr    = 1'b1;
        wd_sel    = 2'b01;
        state_nx  = S_FETCH;
        count_inc = 1'b1;
      end
      S_BRANCH: begin
        alu_op    = ALU_SUB;
        pc_wr     = zero;
        npc_sel   = 3'b001;
        state_nx  = S_FETCH;
        count_inc = 1'b1;
      end
      S_JUMP: begin
        pc_wr   = 1'b1;
        npc_sel = is_jr ? 3'b011 : 3'b010;
        if (is_jal) begin
          reg_wr = 1'b1;
          rd_sel = 2'b10;
          wd_sel = 2'b10;
        end
        state_nx  = S_FETCH;
        count_inc = 1'b1;
      end
      default: state_nx = S_FETCH;
    endcase
    // Outputs are forced quiet during reset so an in-flight request is withdrawn at once.
    if (!reset_n) begin
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      mem_isd  = 1'b0;
      ir_wr    = 1'b0;
      pc_wr    = 1'b0;
      npc_sel  = 3'b000;
      reg_wr   = 1'b0;
      rd_sel   = 2'b00;
      wd_sel   = 2'b00;
      alub_sel = 2'b00;
      alu_op   = ALU_ADD;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed and randomized bench for multicycle_ctrl against an instruction-level trace model.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [5:0]  op, funct;
  logic        zero, mem_ack;
  logic        mem_req, mem_we, mem_isd, ir_wr, pc_wr, reg_wr, illegal;
  logic [2:0]  npc_sel, alu_op;
  logic [1:0]  rd_sel, wd_sel, alub_sel;
  logic [31:0] retired;
  logic [3:0]  state_dbg;

  int errors = 0;
  int checks = 0;
  logic [17:0] exp_q[$];
  bit          ack_q[$];
  logic [31:0] exp_retired;
  logic        exp_illegal;

  multicycle_ctrl #(.CNT_W(32), .ALUOP_W(3)) dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_isd(mem_isd), .ir_wr(ir_wr), .pc_wr(pc_wr),
    .npc_sel(npc_sel), .reg_wr(reg_wr), .rd_sel(rd_sel), .wd_sel(wd_sel),
    .alub_sel(alub_sel), .alu_op(alu_op), .retired(retired), .illegal(illegal),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Instruction table: {op, funct}
  localparam int N_INSTR = 13;
  logic [11:0] itab [N_INSTR] = '{
    {6'h00, 6'h21}, {6'h00, 6'h23}, {6'h0d, 6'h00}, {6'h0f, 6'h00}, {6'h23, 6'h00},
    {6'h2b, 6'h00}, {6'h04, 6'h00}, {6'h02, 6'h00}, {6'h03, 6'h00}, {6'h00, 6'h08},
    {6'h00, 6'h00}, {6'h3f, 6'h00}, {6'h00, 6'h2a}
  };

  function automatic logic [17:0] ov(bit req, bit we, bit isd, bit irw, bit pcw,
                                     logic [2:0] npc, bit rw, logic [1:0] rd, logic [1:0] wd,
                                     logic [1:0] ab, logic [2:0] ao);
    return {req, we, isd, irw, pcw, npc, rw, rd, wd, ab, ao};
  endfunction

  function automatic logic [17:0] observed();
    return {mem_req, mem_we, mem_isd, ir_wr, pc_wr, npc_sel, reg_wr, rd_sel, wd_sel,
            alub_sel, alu_op};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, want);
    end
  endtask

  function automatic bit is_illegal(logic [5:0] o, logic [5:0] f);
    if (o == 6'h00) return !(f inside {6'h21, 6'h23, 6'h08, 6'h00});
    return !(o inside {6'h02, 6'h03, 6'h04, 6'h0d, 6'h0f, 6'h23, 6'h2b});
  endfunction

  // Expected cycle-by-cycle outputs for one whole instruction, fetch through last step.
  task automatic build(input logic [5:0] o, input logic [5:0] f, input logic z,
                       input int fd, input int md);
    exp_q.delete();
    ack_q.delete();
    for (int i = 0; i < fd; i++) begin
      exp_q.push_back(ov(1, 0, 0, 0, 0, 3'b000, 0, 2'b00, 2'b00, 2'b00, 3'b000));
      ack_q.push_back(1'b0);
    end
    exp_q.push_back(ov(1, 0, 0, 1, 1, 3'b000, 0, 2'b00, 2'b00, 2'b00, 3'b000));
    ack_q.push_back(1'b1);
    exp_q.push_back('0);
    ack_q.push_back(1'($urandom));
    if (is_illegal(o, f) || (o == 6'h00 && f == 6'h00)) return;
    case (o)
      6'h00: begin
        if (f == 6'h08) begin
          exp_q.push_back(ov(0, 0, 0, 0, 1, 3'b011, 0, 2'b00, 2'b00, 2'b00, 3'b000));
        end else begin
          exp_q.push_back(ov(0, 0, 0, 0, 0, 3'b000, 0, 2'b00, 2'b00, 2'b00,
                             (f == 6'h23) ? 3'b001 : 3'b000));
          exp_q.push_back(ov(0, 0, 0, 0, 0, 3'b000, 1, 2'b01, 2'b00, 2'b00, 3'b000));
          ack_q.push_back(1'($urandom));
        end
      end
      6'h0d, 6'h0f: begin
        if (o == 6'h0d)
          exp_q.push_back(ov(0, 0, 0, 0, 0, 3'b000, 0, 2'b00, 2'b00, 2'b01, 3'b010));
        else
          exp_q.push_back(ov(0, 0, 0, 0, 0, 3'b000, 0, 2'b00, 2'b00, 2'b11, 3'b000));
        exp_q.push_back(ov(0, 0, 0, 0, 0, 3'b000, 1, 2'b00, 2'b00, 2'b00, 3'b000));
        ack_q.push_back(1'($urandom));
      end
      6'h23, 6'h2b: begin
        exp_q.push_back(ov(0, 0, 0, 0, 0, 3'b000, 0, 2'b00, 2'b00, 2'b10, 3'b000));
        ack_q.push_back(1'($urandom));
        for (int i = 0; i <= md; i++) begin
          exp_q.push_back(ov(1, o == 6'h2b, 1, 0, 0, 3'b000, 0, 2'b00, 2'b00, 2'b00, 3'b000));
          ack_q.push_back(i == md);
        end
        if (o == 6'h23)
          exp_q.push_back(ov(0, 0, 0, 0, 0, 3'b000, 1, 2'b00, 2'b01, 2'b00, 3'b000));
      end
      6'h04: exp_q.push_back(ov(0, 0, 0, 0, z, 3'b001, 0, 2'b00, 2'b00, 2'b00, 3'b001));
      6'h02: exp_q.push_back(ov(0, 0, 0, 0, 1, 3'b010, 0, 2'b00, 2'b00, 2'b00, 3'b000));
      6'h03: exp_q.push_back(ov(0, 0, 0, 0, 1, 3'b010, 1, 2'b10, 2'b10, 2'b00, 3'b000));
      default: ;
    endcase
    while (ack_q.size() < exp_q.size()) ack_q.push_back(1'($urandom));
  endtask

  // Drives one instruction; stop_at>=0 abandons it after that many cycles (for reset tests).
  task automatic run(input string tag, input logic [5:0] o, input logic [5:0] f,
                     input logic z, input int fd, input int md, input int stop_at);
    int n;
    build(o, f, z, fd, md);
    n = (stop_at >= 0) ? stop_at : exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      op = o; funct = f; zero = z; mem_ack = ack_q[i];
      #1;
      check($sformatf("%s_cyc%0d", tag, i), 32'(observed()), 32'(exp_q[i]));
    end
    if (stop_at >= 0) return;
    if (!is_illegal(o, f)) exp_retired = exp_retired + 32'd1;
    else exp_illegal = 1'b1;
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    check({tag, "_retired"}, retired, exp_retired);
    check({tag, "_illegal"}, 32'(illegal), 32'(exp_illegal));
  endtask

  initial begin
    int k;
    reset_n = 1'b0; op = '0; funct = '0; zero = 1'b0; mem_ack = 1'b0;
    exp_retired = '0; exp_illegal = 1'b0;
    repeat (2) @(negedge clk);
    mem_ack = 1'b1;
    #1;
    check("reset_outputs", 32'(observed()), 32'd0);
    check("reset_retired", retired, 32'd0);
    check("reset_illegal", 32'(illegal), 32'd0);
    @(negedge clk);
    reset_n = 1'b1; mem_ack = 1'b0;
    #1;
    check("post_reset_fetch", 32'(observed()),
          32'(ov(1, 0, 0, 0, 0, 3'b000, 0, 2'b00, 2'b00, 2'b00, 3'b000)));

    run("addu", 6'h00, 6'h21, 1'b0, 0, 0, -1);
    run("lw",   6'h23, 6'h00, 1'b0, 3, 3, -1);
    run("beq1", 6'h04, 6'h00, 1'b1, 0, 0, -1);
    run("beq0", 6'h04, 6'h00, 1'b0, 1, 0, -1);
    run("jal",  6'h03, 6'h00, 1'b0, 0, 0, -1);
    run("jr",   6'h00, 6'h08, 1'b0, 2, 0, -1);
    run("j",    6'h02, 6'h00, 1'b0, 0, 0, -1);
    run("subu", 6'h00, 6'h23, 1'b0, 0, 0, -1);
    run("ori",  6'h0d, 6'h00, 1'b0, 1, 0, -1);
    run("lui",  6'h0f, 6'h00, 1'b0, 0, 0, -1);
    run("sw",   6'h2b, 6'h00, 1'b0, 0, 2, -1);
    run("nop",  6'h00, 6'h00, 1'b0, 0, 0, -1);
    run("ill3f", 6'h3f, 6'h00, 1'b0, 0, 0, -1);

    for (int i = 0; i < 60; i++) begin
      k = $urandom_range(N_INSTR - 1);
      run($sformatf("rnd%0d", i), itab[k][11:6], itab[k][5:0], 1'($urandom),
          $urandom_range(3), $urandom_range(3), -1);
    end

    // sw abandoned mid MEM wait: fetch, decode, addr, then two wait cycles
    run("sw_rst", 6'h2b, 6'h00, 1'b0, 0, 3, 5);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst_req", 32'(mem_req), 32'd0);
    check("midrst_outputs", 32'(observed()), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    exp_retired = '0; exp_illegal = 1'b0;
    #1;
    check("midrst_fetch", 32'(observed()),
          32'(ov(1, 0, 0, 0, 0, 3'b000, 0, 2'b00, 2'b00, 2'b00, 3'b000)));
    check("midrst_retired", retired, 32'd0);
    check("midrst_illegal", 32'(illegal), 32'd0);
    run("addu2", 6'h00, 6'h21, 1'b0, 1, 0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
